// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter; serialises one byte per trmt strobe, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int              CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]      LAST_BIT = 4'd9;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] TRANSMIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shft_q, shft_d;
  logic             tx_done_q, tx_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shft_q     <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shft_q     <= shft_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shft_d     = shft_q;
    tx_done_d  = tx_done_q;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          shft_d     = {tx_data, 1'b0};
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_done_d  = 1'b0;
          state_d    = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (baud_cnt_q == BAUD_MAX) begin
          // Shifting in 1s makes the stop bit and the idle line fall out naturally.
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          shft_d     = {1'b1, shft_q[8:1]};
          if (bit_cnt_q == LAST_BIT) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TX      = (state_q == TRANSMIT) ? shft_q[0] : 1'b1;
    tx_done = tx_done_q;
  end

endmodule

`default_nettype wire
